// File: rtl/legv8_mem_bus_ctrl.sv
`default_nettype none
// =============================================================================
//  Module  : legv8_mem_bus_ctrl
//  Brief   : LEGv8 datapath to N-region memory bus with req/done handshake,
//            wait states, read-only protection and size/alignment faults.
//  Revision: 1.0 - initial release
// =============================================================================
module legv8_mem_bus_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 64,
  parameter int NUM_REGIONS = 2,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = {32'h20000000, 32'h00000000},
  parameter logic [NUM_REGIONS*8-1:0]      REGION_AW   = {8'd8, 8'd10},
  parameter logic [NUM_REGIONS*4-1:0]      REGION_WAIT = {4'd1, 4'd0},
  parameter logic [NUM_REGIONS-1:0]        REGION_RO   = 2'b10
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          req,
  output logic                          req_ready,
  input  logic                          req_we,
  input  logic [1:0]                    req_size,
  input  logic [ADDR_W-1:0]             req_addr,
  input  logic [DATA_W-1:0]             req_wdata,
  output logic                          done,
  output logic                          fault,
  output logic [1:0]                    fault_code,
  output logic [DATA_W-1:0]             rdata,
  output logic [NUM_REGIONS-1:0]        mem_cs,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [1:0]                    mem_size,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [NUM_REGIONS*DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t                   r_state;
  logic                     r_we;
  logic [1:0]               r_idx;
  logic [3:0]               r_cnt;

  logic [NUM_REGIONS-1:0]   w_hit_vec;
  logic [ADDR_W-1:0]        w_off [NUM_REGIONS];
  logic [DATA_W-1:0]        w_rd  [NUM_REGIONS];

  logic                     w_hit;
  logic [1:0]               w_idx;
  logic [NUM_REGIONS-1:0]   w_onehot;
  logic [ADDR_W-1:0]        w_offset;
  logic [3:0]               w_wait;
  logic                     w_ro;
  logic                     w_misaligned;
  logic [1:0]               w_code;
  logic [DATA_W-1:0]        w_sel_rd;
  logic [DATA_W-1:0]        w_masked;

  for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_region
    localparam logic [ADDR_W-1:0] c_base = REGION_BASE[g*ADDR_W +: ADDR_W];
    localparam int                c_aw   = int'(REGION_AW[g*8 +: 8]);
    logic [ADDR_W-1:0] w_diff;
    assign w_diff       = req_addr - c_base;
    // A hit already bounds the difference below 2**AW, so it is the offset.
    assign w_hit_vec[g] = (req_addr >= c_base) && ((w_diff >> c_aw) == '0);
    assign w_off[g]     = w_diff;
    assign w_rd[g]      = mem_rdata[g*DATA_W +: DATA_W];
  end

  // Walk from the top so the lowest-index hit overwrites the others.
  always_comb begin
    w_hit    = 1'b0;
    w_idx    = '0;
    w_onehot = '0;
    w_offset = '0;
    w_wait   = '0;
    w_ro     = 1'b0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (w_hit_vec[i]) begin
        w_hit       = 1'b1;
        w_idx       = i[1:0];
        w_onehot    = '0;
        w_onehot[i] = 1'b1;
        w_offset    = w_off[i];
        w_wait      = REGION_WAIT[i*4 +: 4];
        w_ro        = REGION_RO[i];
      end
    end
  end

  always_comb begin
    unique case (req_size)
      2'b00:   w_misaligned = 1'b0;
      2'b01:   w_misaligned = req_addr[0];
      2'b10:   w_misaligned = |req_addr[1:0];
      default: w_misaligned = |req_addr[2:0];
    endcase
    if (w_misaligned)      w_code = 2'b10;
    else if (!w_hit)       w_code = 2'b01;
    else if (req_we && w_ro) w_code = 2'b11;
    else                   w_code = 2'b00;
  end

  always_comb begin
    w_sel_rd = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (r_idx == i[1:0]) w_sel_rd = w_rd[i];
    end
    unique case (mem_size)
      2'b00:   w_masked = {{(DATA_W-8){1'b0}},  w_sel_rd[7:0]};
      2'b01:   w_masked = {{(DATA_W-16){1'b0}}, w_sel_rd[15:0]};
      2'b10:   w_masked = {{(DATA_W-32){1'b0}}, w_sel_rd[31:0]};
      default: w_masked = w_sel_rd;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_we       <= 1'b0;
      r_idx      <= '0;
      r_cnt      <= '0;
      req_ready  <= 1'b1;
      done       <= 1'b0;
      fault      <= 1'b0;
      fault_code <= 2'b00;
      rdata      <= '0;
      mem_cs     <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_size   <= 2'b00;
      mem_wdata  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (req) begin
            req_ready <= 1'b0;
            if (w_code != 2'b00) begin
              r_state    <= S_RESP;
              done       <= 1'b1;
              fault      <= 1'b1;
              fault_code <= w_code;
              rdata      <= '0;
            end else begin
              r_state   <= S_ACCESS;
              r_we      <= req_we;
              r_idx     <= w_idx;
              r_cnt     <= w_wait;
              mem_cs    <= w_onehot;
              mem_we    <= req_we && (w_wait == 4'd0);
              mem_addr  <= w_offset;
              mem_size  <= req_size;
              mem_wdata <= req_wdata;
            end
          end
        end
        S_ACCESS: begin
          if (r_cnt == 4'd0) begin
            r_state    <= S_RESP;
            mem_cs     <= '0;
            mem_we     <= 1'b0;
            done       <= 1'b1;
            fault      <= 1'b0;
            fault_code <= 2'b00;
            rdata      <= r_we ? '0 : w_masked;
          end else begin
            r_cnt  <= r_cnt - 4'd1;
            // Strobe lands in the final wait cycle only.
            mem_we <= r_we && (r_cnt == 4'd1);
          end
        end
        S_RESP: begin
          r_state   <= S_IDLE;
          done      <= 1'b0;
          req_ready <= 1'b1;
        end
        default: begin
          r_state   <= S_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_legv8_mem_bus_ctrl.sv
`default_nettype none
// =============================================================================
//  Module  : tb_legv8_mem_bus_ctrl
//  Brief   : Scoreboard bench for legv8_mem_bus_ctrl with RAM/ROM models.
//  Revision: 1.0 - initial release
// =============================================================================
module tb_legv8_mem_bus_ctrl;

  logic         clock = 1'b0;
  logic         reset;
  logic         req;
  logic         req_ready;
  logic         req_we;
  logic [1:0]   req_size;
  logic [31:0]  req_addr;
  logic [63:0]  req_wdata;
  logic         done;
  logic         fault;
  logic [1:0]   fault_code;
  logic [63:0]  rdata;
  logic [1:0]   mem_cs;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [1:0]   mem_size;
  logic [63:0]  mem_wdata;
  logic [127:0] mem_rdata;

  legv8_mem_bus_ctrl dut (
    .clock(clock), .reset(reset), .req(req), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .done(done), .fault(fault), .fault_code(fault_code), .rdata(rdata),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_size(mem_size),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        fault;
    logic [1:0]  code;
    logic [63:0] rd;
    int          lat;
    int          cs_cyc;
    int          we_cyc;
    logic [1:0]  cs;
    logic [31:0] off;
    int          acc;
  } exp_t;

  exp_t        q[$];
  int          n_checks = 0;
  int          errors   = 0;
  int          cyc      = 0;
  int          cs_cnt   = 0;
  int          we_cnt   = 0;
  logic        ram_clr;
  logic [7:0]  ram [1024];
  logic [63:0] ram_rd;
  logic [63:0] rom_word;

  always @(posedge clock) cyc <= cyc + 1;

  always_comb begin
    ram_rd = '0;
    for (int k = 0; k < 8; k++) ram_rd[k*8 +: 8] = ram[mem_addr[9:0] + 10'(k)];
  end
  assign mem_rdata = {rom_word, ram_rd};

  always @(posedge clock) begin
    if (ram_clr) begin
      for (int k = 0; k < 1024; k++) ram[k] <= 8'h00;
    end else if (mem_cs[0] && mem_we) begin
      for (int k = 0; k < 8; k++)
        if (k < (1 << mem_size)) ram[mem_addr[9:0] + 10'(k)] <= mem_wdata[k*8 +: 8];
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  // Monitor: per-cycle bus checks against the head entry, full compare on done.
  always @(negedge clock) begin
    if (reset) begin
      if (mem_cs != 2'b00) begin
        if (q.size() == 0) chk("cs_without_txn", 64'(mem_cs), 64'd0);
        else begin
          chk("mem_cs", 64'(mem_cs), 64'(q[0].cs));
          chk("mem_addr", 64'(mem_addr), 64'(q[0].off));
        end
        cs_cnt++;
      end
      if (mem_we) we_cnt++;
      if (done) begin
        if (q.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("fault", 64'(fault), 64'(e.fault));
          chk("fault_code", 64'(fault_code), 64'(e.code));
          chk("rdata", rdata, e.rd);
          chk("latency", 64'(cyc - e.acc + 1), 64'(e.lat));
          chk("cs_cycles", 64'(cs_cnt), 64'(e.cs_cyc));
          chk("we_cycles", 64'(we_cnt), 64'(e.we_cyc));
        end
        cs_cnt = 0;
        we_cnt = 0;
      end
    end
  end

  task automatic issue(input logic we, input logic [1:0] sz, input logic [31:0] a,
                       input logic [63:0] wd, input logic [1:0] code, input logic [63:0] rd,
                       input int lat, input int csc, input int wec,
                       input logic [1:0] cs, input logic [31:0] off);
    exp_t e;
    int   t;
    t = 0;
    @(negedge clock);
    while (!req_ready && t < 40) begin
      @(negedge clock);
      t++;
    end
    if (!req_ready) chk("accept_timeout", 64'd0, 64'd1);
    else begin
      req = 1'b1; req_we = we; req_size = sz; req_addr = a; req_wdata = wd;
      e.fault = (code != 2'b00); e.code = code; e.rd = rd; e.lat = lat;
      e.cs_cyc = csc; e.we_cyc = wec; e.cs = cs; e.off = off; e.acc = cyc + 1;
      q.push_back(e);
      @(posedge clock);
      #1 req = 1'b0;
    end
  endtask

  // Pull reset inside the ACCESS cycle that follows an accept.
  task automatic abort_access();
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("rst_mem_cs", 64'(mem_cs), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_done", 64'(done), 64'd0);
    q.delete();
    cs_cnt = 0;
    we_cnt = 0;
    @(negedge clock);
    #2 reset = 1'b1;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (q.size() != 0 && t < 40) begin
      @(negedge clock);
      t++;
    end
    if (q.size() != 0) chk("drain_timeout", 64'(q.size()), 64'd0);
    repeat (2) @(negedge clock);
  endtask

  initial begin
    reset = 1'b0; req = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_addr = '0; req_wdata = '0; ram_clr = 1'b1; rom_word = '0;
    repeat (3) @(negedge clock);
    chk("reset_req_ready", 64'(req_ready), 64'd1);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_fault", 64'(fault), 64'd0);
    chk("reset_code", 64'(fault_code), 64'd0);
    chk("reset_rdata", rdata, 64'd0);
    chk("reset_mem_cs", 64'(mem_cs), 64'd0);
    chk("reset_mem_we", 64'(mem_we), 64'd0);
    chk("reset_mem_addr", 64'(mem_addr), 64'd0);
    reset = 1'b1;
    ram_clr = 1'b0;

    // RAM dword write/read, word read
    issue(1, 2'b11, 32'h8, 64'h0123456789ABCDEF, 2'b00, 64'h0, 2, 1, 1, 2'b01, 32'h8);
    issue(0, 2'b11, 32'h8, 64'h0, 2'b00, 64'h0123456789ABCDEF, 2, 1, 0, 2'b01, 32'h8);
    issue(0, 2'b10, 32'h8, 64'h0, 2'b00, 64'h0000000089ABCDEF, 2, 1, 0, 2'b01, 32'h8);
    wait_idle();

    // ROM reads with one wait state
    rom_word = 64'hFFFFFFFF_DEADBEEF;
    issue(0, 2'b10, 32'h20000004, 64'h0, 2'b00, 64'h00000000DEADBEEF, 3, 2, 0, 2'b10, 32'h4);
    issue(0, 2'b00, 32'h200000FF, 64'h0, 2'b00, 64'h00000000000000EF, 3, 2, 0, 2'b10, 32'hFF);
    issue(0, 2'b11, 32'h000003F8, 64'h0, 2'b00, 64'h0, 2, 1, 0, 2'b01, 32'h3F8);

    // Faults: read-only, misaligned, unmapped, boundaries
    issue(1, 2'b11, 32'h20000000, 64'h1111, 2'b11, 64'h0, 1, 0, 0, 2'b00, 32'h0);
    issue(0, 2'b01, 32'h00000003, 64'h0, 2'b10, 64'h0, 1, 0, 0, 2'b00, 32'h0);
    issue(0, 2'b11, 32'h10000000, 64'h0, 2'b01, 64'h0, 1, 0, 0, 2'b00, 32'h0);
    issue(0, 2'b01, 32'h10000001, 64'h0, 2'b10, 64'h0, 1, 0, 0, 2'b00, 32'h0);
    issue(1, 2'b10, 32'h20000002, 64'h0, 2'b10, 64'h0, 1, 0, 0, 2'b00, 32'h0);
    issue(0, 2'b00, 32'h00000400, 64'h0, 2'b01, 64'h0, 1, 0, 0, 2'b00, 32'h0);
    issue(0, 2'b00, 32'h20000100, 64'h0, 2'b01, 64'h0, 1, 0, 0, 2'b00, 32'h0);
    wait_idle();

    // Reset mid-access: ROM read, then RAM write that must not land
    issue(0, 2'b10, 32'h20000004, 64'h0, 2'b00, 64'h0, 3, 2, 0, 2'b10, 32'h4);
    abort_access();
    issue(1, 2'b11, 32'h10, 64'h5555555555555555, 2'b00, 64'h0, 2, 1, 1, 2'b01, 32'h10);
    abort_access();
    issue(0, 2'b11, 32'h10, 64'h0, 2'b00, 64'h0, 2, 1, 0, 2'b01, 32'h10);
    wait_idle();

    // req held high through ACCESS/RESP with changed fields: only one capture
    begin
      exp_t e;
      int   t;
      @(negedge clock);
      req = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h20000004; req_wdata = '0;
      e.fault = 1'b0; e.code = 2'b00; e.rd = 64'h00000000DEADBEEF; e.lat = 3;
      e.cs_cyc = 2; e.we_cyc = 0; e.cs = 2'b10; e.off = 32'h4; e.acc = cyc + 1;
      q.push_back(e);
      @(posedge clock);
      #1 req_addr = 32'h8; req_size = 2'b11; req_we = 1'b1;
      t = 0;
      @(negedge clock);
      while (!done && t < 20) begin
        @(negedge clock);
        t++;
      end
      if (!done) chk("busy_done_timeout", 64'd0, 64'd1);
      req = 1'b0;
    end
    wait_idle();

    // Back-to-back byte writes, then readbacks of several sizes
    issue(1, 2'b00, 32'h1, 64'h11223344556677AA, 2'b00, 64'h0, 2, 1, 1, 2'b01, 32'h1);
    issue(1, 2'b00, 32'h2, 64'h00000000000000BB, 2'b00, 64'h0, 2, 1, 1, 2'b01, 32'h2);
    issue(0, 2'b00, 32'h1, 64'h0, 2'b00, 64'h00000000000000AA, 2, 1, 0, 2'b01, 32'h1);
    issue(0, 2'b00, 32'h2, 64'h0, 2'b00, 64'h00000000000000BB, 2, 1, 0, 2'b01, 32'h2);
    issue(0, 2'b01, 32'h0, 64'h0, 2'b00, 64'h000000000000AA00, 2, 1, 0, 2'b01, 32'h0);
    issue(0, 2'b11, 32'h0, 64'h0, 2'b00, 64'h0000000000BBAA00, 2, 1, 0, 2'b01, 32'h0);
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
